mux_sel_arbiter: RTL and testbench

- Two-requester round-robin arbiter that generates the registered `sel` driving the 2:1 data mux directly downstream.
- Each input requests ownership of the mux for a burst of beats; the grant is held until the burst's last beat is accepted by the consumer, or until a beat-count limit forces release.
- Provides the one-hot grant, output valid and per-burst beat count to the surrounding datapath.

---
 rtl/mux_sel_arbiter.sv | 119 +++++++++++
 tb/tb_mux_sel_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_sel_arbiter.sv
// Two-requester round-robin arbiter producing the registered select of the
// downstream 2:1 data mux. An owner keeps the mux for a burst of beats and
// gives it up on its last accepted beat or when the beat limit is reached.
//
// Handshake: a beat moves (xfer) in any cycle where out_valid and out_ready
// are both high. out_valid means the granted input has a beat available.
// out_ready may be high while out_valid is low; nothing moves then.
//
// Release decision: the other input is checked first, so a waiting requester
// gets a zero-bubble handoff. If the other input is not requesting:
//   - release on a last beat: the burst is complete, so the arbiter returns
//     to IDLE;
//   - forced release at the beat limit: the owner still has beats pending,
//     so it starts a new burst and keeps the mux.
// State is visible on dbg_state (0 = IDLE, 1 = OWN0, 2 = OWN1).
module mux_sel_arbiter #(
  parameter  int MAX_BURST = 8,
  localparam int CNT_W     = $clog2(MAX_BURST + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_0,
  input  logic             req_1,
  input  logic             last_0,
  input  logic             last_1,
  input  logic             out_ready,
  output logic             sel,
  output logic             gnt_0,
  output logic             gnt_1,
  output logic             out_valid,
  output logic [CNT_W-1:0] beat_cnt,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OWN0 = 2'd1,
    S_OWN1 = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_prio;
  logic             w_prio_next;
  logic             r_sel;
  logic [CNT_W-1:0] r_cnt;
  logic             w_xfer;
  logic             w_last;
  logic             w_at_limit;
  logic             w_rel;

  assign gnt_0     = (r_state == S_OWN0);
  assign gnt_1     = (r_state == S_OWN1);
  assign out_valid = (gnt_0 & req_0) | (gnt_1 & req_1);
  assign sel       = r_sel;
  assign beat_cnt  = r_cnt;
  assign dbg_state = r_state;

  assign w_xfer     = out_valid & out_ready;
  assign w_last     = gnt_1 ? last_1 : last_0;
  assign w_at_limit = (r_cnt == CNT_W'(MAX_BURST - 1));
  assign w_rel      = w_xfer & (w_last | w_at_limit);

  // Next-state and priority pointer selection.
  always_comb begin
    w_next      = r_state;
    w_prio_next = r_prio;
    unique case (r_state)
      S_IDLE: begin
        if (req_0 && req_1) w_next = r_prio ? S_OWN1 : S_OWN0;
        else if (req_0)     w_next = S_OWN0;
        else if (req_1)     w_next = S_OWN1;
      end
      S_OWN0: begin
        if (w_rel) begin
          w_prio_next = 1'b1;
          if (req_1)        w_next = S_OWN1;
          else if (!w_last) w_next = S_OWN0;
          else              w_next = S_IDLE;
        end
      end
      S_OWN1: begin
        if (w_rel) begin
          w_prio_next = 1'b0;
          if (req_0)        w_next = S_OWN0;
          else if (!w_last) w_next = S_OWN1;
          else              w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State, priority and select registers; select holds its value in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_prio  <= 1'b0;
      r_sel   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_prio  <= w_prio_next;
      if (w_next == S_OWN0)      r_sel <= 1'b0;
      else if (w_next == S_OWN1) r_sel <= 1'b1;
    end
  end

  // Beat counter: counts accepted beats, cleared when the grant is released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_rel) begin
      r_cnt <= '0;
    end else if (w_xfer) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Bench for mux_sel_arbiter: directed scenarios plus random traffic, all
// compared each cycle against a behavioural model of the arbitration rules.
module tb_mux_sel_arbiter;

  localparam int MAXB = 8;
  localparam int CW   = $clog2(MAXB + 1);
  localparam int VW   = 4 + CW;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_0, req_1, last_0, last_1, out_ready;
  logic          sel, gnt_0, gnt_1, out_valid;
  logic [CW-1:0] beat_cnt;
  logic [1:0]    dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: owner is -1 (none), 0 or 1.
  int m_owner, m_prio, m_cnt, m_sel;

  wire [VW-1:0] w_obs = {sel, gnt_0, gnt_1, out_valid, beat_cnt};

  mux_sel_arbiter #(.MAX_BURST(MAXB)) dut (
    .clk(clk), .rst(rst), .req_0(req_0), .req_1(req_1),
    .last_0(last_0), .last_1(last_1), .out_ready(out_ready),
    .sel(sel), .gnt_0(gnt_0), .gnt_1(gnt_1), .out_valid(out_valid),
    .beat_cnt(beat_cnt), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  function automatic bit req_of(int who);
    return (who == 0) ? bit'(req_0) : bit'(req_1);
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    logic v;
    v = (m_owner >= 0) && req_of(m_owner);
    return {m_sel[0], m_owner == 0, m_owner == 1, v, m_cnt[CW-1:0]};
  endfunction

  task automatic model_reset();
    m_owner = -1; m_prio = 0; m_cnt = 0; m_sel = 0;
  endtask

  // One clock of the arbitration rules, evaluated on the inputs at the edge.
  task automatic model_step();
    bit x, lst;
    int other;
    if (m_owner < 0) begin
      if (req_0 && req_1) m_owner = m_prio;
      else if (req_0)     m_owner = 0;
      else if (req_1)     m_owner = 1;
    end else begin
      x   = req_of(m_owner) && out_ready;
      lst = (m_owner == 0) ? bit'(last_0) : bit'(last_1);
      if (x && (lst || m_cnt + 1 == MAXB)) begin
        m_cnt  = 0;
        other  = 1 - m_owner;
        m_prio = other;
        if (req_of(other)) m_owner = other;
        else if (lst)      m_owner = -1;
      end else if (x) begin
        m_cnt = m_cnt + 1;
      end
    end
    if (m_owner >= 0) m_sel = m_owner;
  endtask

  task automatic cyc();
    @(posedge clk);
    if (rst) model_reset(); else model_step();
    @(negedge clk);
  endtask

  task automatic drive(input bit r0, l0, r1, l1, rdy);
    req_0 = r0; last_0 = l0; req_1 = r1; last_1 = l1; out_ready = rdy;
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && m_owner >= 0; i++) begin
      drive(m_owner == 0, 1, m_owner == 1, 1, 1);
      #1;
      n_checks++;
      if (w_obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL drain cyc %0d: got %b expected %b", i, w_obs, exp_vec());
      end
      cyc();
    end
    drive(0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, 1);
    rst = 1'b1;
    model_reset();
    repeat (2) cyc();
    n_checks++;
    if (w_obs !== {VW{1'b0}}) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected %b", w_obs, {VW{1'b0}});
    end
    rst = 1'b0;
    cyc();
    n_checks++;
    if (w_obs !== exp_vec()) begin
      n_fail++;
      $display("FAIL reset_release_idle: got %b expected %b", w_obs, exp_vec());
    end
  endtask

  task automatic test_single_beat();
    bit [2:0] rows [4] = '{3'b111, 3'b111, 3'b000, 3'b000};
    for (int i = 0; i < 4; i++) begin
      drive(rows[i][2], rows[i][1], 0, 0, rows[i][0]);
      #1;
      n_checks++;
      if (w_obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL single_beat row %0d: got %b expected %b", i, w_obs, exp_vec());
      end
      cyc();
    end
    n_checks++;
    if (gnt_0 !== 1'b0 || beat_cnt !== '0) begin
      n_fail++;
      $display("FAIL single_beat_idle: got gnt_0=%b cnt=%0d expected 0,0", gnt_0, beat_cnt);
    end
  endtask

  task automatic test_alternation();
    int switches = 0;
    logic prev_sel;
    prev_sel = sel;
    for (int i = 0; i < 13; i++) begin
      drive(1, m_cnt == 1, 1, m_cnt == 1, 1);
      #1;
      n_checks++;
      if (w_obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL alternation cyc %0d: got %b expected %b", i, w_obs, exp_vec());
      end
      if (i > 1 && sel !== prev_sel) switches++;
      prev_sel = sel;
      cyc();
    end
    n_checks++;
    if (switches != 5) begin
      n_fail++;
      $display("FAIL alternation_sel_toggles: got %0d expected 5", switches);
    end
    drain();
  endtask

  task automatic test_stall_gap();
    bit [2:0] rows [8] = '{3'b101, 3'b101, 3'b100, 3'b001, 3'b101,
                           3'b111, 3'b000, 3'b000};
    drain();
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, rows[i][2], rows[i][1], rows[i][0]);
      #1;
      n_checks++;
      if (w_obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL stall_gap row %0d: got %b expected %b", i, w_obs, exp_vec());
      end
      if (i == 5) begin
        n_checks++;
        if (beat_cnt !== CW'(2) || sel !== 1'b1 || gnt_1 !== 1'b1) begin
          n_fail++;
          $display("FAIL stall_gap_last_beat: got cnt=%0d sel=%b gnt_1=%b expected 2,1,1",
                   beat_cnt, sel, gnt_1);
        end
      end
      cyc();
    end
  endtask

  task automatic test_forced_release();
    int beats0 = 0;
    bit seen1 = 0;
    drain();
    for (int i = 0; i < 14; i++) begin
      drive(1, 0, 1, 1, 1);
      #1;
      n_checks++;
      if (w_obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL forced_release cyc %0d: got %b expected %b", i, w_obs, exp_vec());
      end
      if (gnt_1) seen1 = 1;
      if (!seen1 && gnt_0 && out_valid && out_ready) beats0++;
      cyc();
    end
    n_checks++;
    if (beats0 != MAXB || !seen1) begin
      n_fail++;
      $display("FAIL forced_release_beats: got %0d (gnt_1 seen %0d) expected %0d", beats0, seen1, MAXB);
    end
    drain();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 3) != 0);
      #1;
      n_checks++;
      if (w_obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL random cyc %0d: got %b expected %b", i, w_obs, exp_vec());
      end
      cyc();
    end
    drain();
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 0, 1);
      #1;
      n_checks++;
      if (w_obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL async_reset_burst cyc %0d: got %b expected %b", i, w_obs, exp_vec());
      end
      cyc();
    end
    #2 rst = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if (w_obs !== {VW{1'b0}}) begin
      n_fail++;
      $display("FAIL async_reset_immediate: got %b expected %b", w_obs, {VW{1'b0}});
    end
    cyc();
    rst = 1'b0;
    drive(1, 1, 1, 1, 1);
    cyc();
    #1;
    n_checks++;
    if (gnt_0 !== 1'b1 || gnt_1 !== 1'b0 || w_obs !== exp_vec()) begin
      n_fail++;
      $display("FAIL async_reset_tie: got %b expected %b", w_obs, exp_vec());
    end
    drain();
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    model_reset();
    test_reset();
    test_single_beat();
    test_alternation();
    test_stall_gap();
    test_forced_release();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
